// File: rtl/fc_post_proc_pkg.sv
// Shared fixed-point helpers for the FC datapath blocks (MAC array, post-processing, pooling).
// All widths and limits derive from these functions, so every block agrees on them.
package fc_post_proc_pkg;

  localparam int FC_ACC_W      = 23;
  localparam int FC_OUT_W      = 16;
  localparam int FC_FRAC_SHIFT = 7;

  // Width of an accumulator after one sign-extension bit is added ahead of the bias add.
  function automatic int fc_sext_w(input int acc_w);
    return acc_w + 1;
  endfunction

  function automatic longint fc_pow2(input int n);
    return longint'(1) << n;
  endfunction

  function automatic longint fc_sat_max(input int w);
    return fc_pow2(w - 1) - longint'(1);
  endfunction

  function automatic longint fc_sat_min(input int w);
    return -fc_pow2(w - 1);
  endfunction

endpackage

// File: rtl/fc_scale_sat.sv
// Combinational rescale: optional round-half-up, arithmetic shift, optional ReLU, saturate or wrap.
// Also used by the conv post-processor, so it stays free of any pipeline state.
module fc_scale_sat
  import fc_post_proc_pkg::*;
#(
  parameter int ACC_W      = FC_ACC_W,
  parameter int OUT_W      = FC_OUT_W,
  parameter int FRAC_SHIFT = FC_FRAC_SHIFT,
  parameter int RELU_EN    = 1,
  parameter int SAT_EN     = 1,
  parameter int ROUND_EN   = 0
) (
  input  logic signed [fc_sext_w(ACC_W)-1:0] sum,
  output logic        [OUT_W-1:0]            res
);

  localparam int SW = fc_sext_w(ACC_W);
  // Wide enough that rounding never overflows and the saturation limits always fit.
  localparam int XW = SW + OUT_W + 1;

  localparam logic signed [XW-1:0] RND   = (ROUND_EN != 0) ? XW'(fc_pow2(FRAC_SHIFT - 1)) : '0;
  localparam logic signed [XW-1:0] MAX_V = XW'(fc_sat_max(OUT_W));
  localparam logic signed [XW-1:0] MIN_V = XW'(fc_sat_min(OUT_W));

  logic signed [XW-1:0] ext;
  logic signed [XW-1:0] shr;

  always_comb begin
    ext = {{(XW-SW){sum[SW-1]}}, sum} + RND;
    shr = ext >>> FRAC_SHIFT;
    if (RELU_EN != 0 && shr[XW-1]) shr = '0;
    res = shr[OUT_W-1:0];
    if (SAT_EN != 0) begin
      if (shr > MAX_V)      res = MAX_V[OUT_W-1:0];
      else if (shr < MIN_V) res = MIN_V[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/fc_post_proc.sv
// FC output post-processor: bias add, rescale and clamp, then write into a per-neuron bank.
// Tracks vector completion through a sticky done flag and a saturating write count.
module fc_post_proc
  import fc_post_proc_pkg::*;
#(
  parameter int ACC_W      = FC_ACC_W,
  parameter int BIAS_W     = 16,
  parameter int OUT_W      = FC_OUT_W,
  parameter int FRAC_SHIFT = FC_FRAC_SHIFT,
  parameter int NUM_OUT    = 10,
  parameter int ADDR_W     = 4,
  parameter int RELU_EN    = 1,
  parameter int SAT_EN     = 1,
  parameter int ROUND_EN   = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              in_valid,
  input  logic [ACC_W-1:0]  in_acc,
  input  logic [BIAS_W-1:0] in_bias,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic              in_last,
  output logic              wr_valid,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [OUT_W-1:0]  rd_data,
  output logic              done,
  output logic [ADDR_W:0]   wr_cnt,
  output logic              err
);

  localparam int SW     = fc_sext_w(ACC_W);
  // vld_pipe[0] qualifies the stage-1 register, vld_pipe[STAGES] the stage-2 register.
  localparam int STAGES = 1;
  localparam logic [ADDR_W:0] NUM_OUT_L = (ADDR_W+1)'(NUM_OUT);

  typedef struct packed {
    logic signed [SW-1:0] sum;
    logic [ADDR_W-1:0]    addr;
    logic                 last;
  } s1_t;

  typedef struct packed {
    logic [OUT_W-1:0]  res;
    logic [ADDR_W-1:0] addr;
    logic              last;
  } s2_t;

  logic [STAGES:0]  vld_pipe;
  s1_t              s1_q;
  s2_t              s2_q;
  logic [OUT_W-1:0] res_d;
  logic [OUT_W-1:0] bank [NUM_OUT];
  logic             in_range;
  logic             wr_miss;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_pipe <= '0;
    else        vld_pipe <= {vld_pipe[STAGES-1:0], in_valid};
  end

  // Data registers carry no reset: the valid pipe alone decides whether they matter.
  always_ff @(posedge clk) begin
    s1_q.sum  <= {in_acc[ACC_W-1], in_acc} + {{(SW-BIAS_W){in_bias[BIAS_W-1]}}, in_bias};
    s1_q.addr <= in_addr;
    s1_q.last <= in_last;
    s2_q.res  <= res_d;
    s2_q.addr <= s1_q.addr;
    s2_q.last <= s1_q.last;
  end

  fc_scale_sat #(
    .ACC_W      (ACC_W),
    .OUT_W      (OUT_W),
    .FRAC_SHIFT (FRAC_SHIFT),
    .RELU_EN    (RELU_EN),
    .SAT_EN     (SAT_EN),
    .ROUND_EN   (ROUND_EN)
  ) u_scale (
    .sum (s1_q.sum),
    .res (res_d)
  );

  assign in_range = {1'b0, s2_q.addr} < NUM_OUT_L;
  assign wr_valid = vld_pipe[STAGES] & in_range;
  assign wr_miss  = vld_pipe[STAGES] & ~in_range;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_OUT; i++) bank[i] <= '0;
    end else if (wr_valid) begin
      for (int i = 0; i < NUM_OUT; i++)
        if (s2_q.addr == ADDR_W'(i)) bank[i] <= s2_q.res;
    end
  end

  // Decoded read keeps addresses beyond NUM_OUT from indexing past the array.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_OUT; i++)
      if (rd_addr == ADDR_W'(i)) rd_data = bank[i];
  end

  // clr beats a coincident commit for status; the bank write above still lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done   <= 1'b0;
      wr_cnt <= '0;
      err    <= 1'b0;
    end else if (clr) begin
      done   <= 1'b0;
      wr_cnt <= '0;
      err    <= 1'b0;
    end else begin
      if (wr_valid) begin
        if (wr_cnt != '1) wr_cnt <= wr_cnt + (ADDR_W+1)'(1);
        if (s2_q.last)    done   <= 1'b1;
      end
      if (wr_miss) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fc_post_proc.sv
// Drives four differently configured post-processors with one stream and checks each one
// every cycle against an integer model of the rescale rules, plus hand-computed literal checks.
module tb_fc_post_proc;

  localparam int NI = 4;
  // Instance 0 uses the default configuration; 1 has no ReLU, 2 wraps, 3 rounds.
  localparam bit [NI-1:0] RELU_C = 4'b1101;
  localparam bit [NI-1:0] SAT_C  = 4'b1011;
  localparam bit [NI-1:0] RND_C  = 4'b1000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr = 1'b0;
  logic        in_valid = 1'b0;
  logic [22:0] in_acc = '0;
  logic [15:0] in_bias = '0;
  logic [3:0]  in_addr = '0;
  logic        in_last = 1'b0;
  logic [3:0]  rd_addr = '0;

  logic        wr_v [NI];
  logic [15:0] rd_d [NI];
  logic        dn   [NI];
  logic [4:0]  cnt  [NI];
  logic        er   [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    fc_post_proc #(
      .RELU_EN  (int'(RELU_C[g])),
      .SAT_EN   (int'(SAT_C[g])),
      .ROUND_EN (int'(RND_C[g]))
    ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (clr),
      .in_valid (in_valid),
      .in_acc   (in_acc),
      .in_bias  (in_bias),
      .in_addr  (in_addr),
      .in_last  (in_last),
      .wr_valid (wr_v[g]),
      .rd_addr  (rd_addr),
      .rd_data  (rd_d[g]),
      .done     (dn[g]),
      .wr_cnt   (cnt[g]),
      .err      (er[g])
    );
  end

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input int g, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s inst%0d t=%0t: got %0h expected %0h", nm, g, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    bit     v;
    longint acc;
    longint bias;
    int     addr;
    bit     last;
  } ent_t;

  ent_t        p1, p2;
  logic [15:0] mbank [NI][10];
  bit          m_done, m_err;
  int          m_cnt;

  function automatic logic [15:0] mdl(input longint acc, input longint bias, input int g);
    longint v;
    v = acc + bias;
    if (RND_C[g]) v = v + 64;
    v = v >>> 7;
    if (RELU_C[g] && v < 0) v = 0;
    if (SAT_C[g]) begin
      if (v > 32767)       v = 32767;
      else if (v < -32768) v = -32768;
    end
    return v[15:0];
  endfunction

  task automatic model_reset();
    p1 = '{v:0, acc:0, bias:0, addr:0, last:0};
    p2 = p1;
    m_done = 0; m_err = 0; m_cnt = 0;
    for (int g = 0; g < NI; g++)
      for (int a = 0; a < 10; a++) mbank[g][a] = '0;
  endtask

  // An element sampled at edge t commits at edge t+2.
  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else begin
        if (p2.v && p2.addr < 10)
          for (int g = 0; g < NI; g++) mbank[g][p2.addr] = mdl(p2.acc, p2.bias, g);
        if (clr) begin
          m_done = 0; m_cnt = 0; m_err = 0;
        end else if (p2.v) begin
          if (p2.addr < 10) begin
            if (m_cnt < 31) m_cnt++;
            if (p2.last) m_done = 1;
          end else m_err = 1;
        end
        p2 = p1;
        p1 = '{v:in_valid, acc:longint'($signed(in_acc)), bias:longint'($signed(in_bias)),
               addr:int'(in_addr), last:in_last};
      end
    end
  end

  // Every-cycle comparison, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        for (int g = 0; g < NI; g++) begin
          chk("wr_valid", g, 32'(wr_v[g]), 32'(p2.v && p2.addr < 10));
          chk("done",     g, 32'(dn[g]),   32'(m_done));
          chk("wr_cnt",   g, 32'(cnt[g]),  32'(m_cnt));
          chk("err",      g, 32'(er[g]),   32'(m_err));
          chk("rd_data",  g, 32'(rd_d[g]), (rd_addr < 10) ? 32'(mbank[g][rd_addr]) : 32'd0);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input bit v, input longint acc, input longint bias, input int addr,
                       input bit last, input bit c);
    in_valid = v;
    in_acc   = 23'(acc);
    in_bias  = 16'(bias);
    in_addr  = 4'(addr);
    in_last  = last;
    clr      = c;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk_en = 1'b1;
    for (int g = 0; g < NI; g++) chk("rst_cnt", g, 32'(cnt[g]), 32'd0);

    // 1: latency and value of 1152 >> 7
    rd_addr = 4'd3;
    drive(1, 1024, 128, 3, 0, 0);
    idle(1);
    chk("t1_wv_early", 0, 32'(wr_v[0]), 32'd1);
    chk("t1_rd_early", 0, 32'(rd_d[0]), 32'd0);
    idle(1);
    chk("t1_rd", 0, 32'(rd_d[0]), 32'd9);
    chk("t1_wv_off", 0, 32'(wr_v[0]), 32'd0);

    // 2: negative result, with and without ReLU
    rd_addr = 4'd0;
    drive(1, -2048, 0, 0, 0, 0);
    idle(2);
    chk("t2_relu", 0, 32'(rd_d[0]), 32'd0);
    chk("t2_norelu", 1, 32'(rd_d[1]), 32'h0000_fff0);

    // 3: overflow, saturated vs wrapped
    rd_addr = 4'd1;
    drive(1, 'h3fffff, 'h7fff, 1, 0, 0);
    idle(2);
    chk("t3_sat", 0, 32'(rd_d[0]), 32'h7fff);
    chk("t3_wrap", 2, 32'(rd_d[2]), 32'h80ff);

    // 4: full vector, then clr
    drive(0, 0, 0, 0, 0, 1);
    for (int k = 0; k < 10; k++) drive(1, k * 128, 0, k, k == 9, 0);
    idle(2);
    chk("t4_done", 0, 32'(dn[0]), 32'd1);
    chk("t4_cnt", 0, 32'(cnt[0]), 32'd10);
    for (int k = 0; k < 10; k++) begin
      rd_addr = 4'(k);
      #1 chk("t4_bank", 0, 32'(rd_d[0]), 32'(k));
    end
    drive(0, 0, 0, 0, 0, 1);
    idle(1);
    chk("t4_clr_done", 0, 32'(dn[0]), 32'd0);
    chk("t4_clr_cnt", 0, 32'(cnt[0]), 32'd0);
    rd_addr = 4'd5;
    #1 chk("t4_keep", 0, 32'(rd_d[0]), 32'd5);

    // 5: round half up
    drive(0, 0, 0, 0, 0, 1);
    rd_addr = 4'd2;
    drive(1, 64, 0, 2, 0, 0);
    idle(2);
    chk("t5_rnd", 3, 32'(rd_d[3]), 32'd1);
    chk("t5_trunc", 0, 32'(rd_d[0]), 32'd0);
    drive(1, 63, 0, 2, 0, 0);
    idle(2);
    chk("t5_rnd63", 3, 32'(rd_d[3]), 32'd0);

    // 6: out-of-range address carrying last
    drive(1, 5, 0, 12, 1, 0);
    idle(2);
    chk("t6_err", 0, 32'(er[0]), 32'd1);
    chk("t6_done", 0, 32'(dn[0]), 32'd0);
    chk("t6_cnt", 0, 32'(cnt[0]), 32'd2);

    // random traffic, including out-of-range reads/writes, rare clr and count saturation
    for (int i = 0; i < 600; i++) begin
      rd_addr = 4'($urandom_range(0, 15));
      drive($urandom_range(0, 3) != 0, longint'($signed(23'($urandom))),
            longint'($signed(16'($urandom))), $urandom_range(0, 15),
            $urandom_range(0, 7) == 0, $urandom_range(0, 59) == 0);
    end
    drive(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 40; i++) drive(1, longint'($urandom_range(0, 4095)), 0, i % 10, 0, 0);
    idle(2);
    chk("sat_cnt", 0, 32'(cnt[0]), 32'd31);

    // reset with two elements in flight
    drive(1, 1000, 0, 4, 1, 0);
    drive(1, 2000, 0, 5, 1, 0);
    rst_n = 1'b0;
    #1;
    for (int g = 0; g < NI; g++) begin
      chk("rst_done", g, 32'(dn[g]), 32'd0);
      chk("rst_err", g, 32'(er[g]), 32'd0);
      chk("rst_cnt2", g, 32'(cnt[g]), 32'd0);
      chk("rst_wv", g, 32'(wr_v[g]), 32'd0);
    end
    for (int k = 0; k < 10; k++) begin
      rd_addr = 4'(k);
      #1 chk("rst_bank", 0, 32'(rd_d[0]), 32'd0);
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      idle(1);
      chk("post_rst_wv", 0, 32'(wr_v[0]), 32'd0);
    end
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
